// File: rtl/pit_engine.sv
// pit_engine: pending interest table with full-depth scan,
// aggregation, data match, FIB forwarding and prescaled aging.
// Ports:
//   clk, reset
//   int_valid/int_ready/int_key/int_face: interest request
//   data_valid/data_ready/data_key: data request
//   fib_out/fib_key, hit/hit_faces, agg, dup, drop, expire: results
//   occupancy: number of valid entries
module pit_engine #(
  parameter int KEY_W    = 12,
  parameter int DEPTH    = 16,
  parameter int FACES    = 4,
  parameter int LIFE_W   = 8,
  parameter int LIFE     = 100,
  parameter int TICK_DIV = 256,
  parameter int FACE_W   = $clog2(FACES),
  parameter int OCC_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              int_valid,
  output logic              int_ready,
  input  logic [KEY_W-1:0]  int_key,
  input  logic [FACE_W-1:0] int_face,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic [KEY_W-1:0]  data_key,
  output logic              fib_out,
  output logic [KEY_W-1:0]  fib_key,
  output logic              hit,
  output logic [FACES-1:0]  hit_faces,
  output logic              agg,
  output logic              dup,
  output logic              drop,
  output logic              expire,
  output logic [OCC_W-1:0]  occupancy
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PS_W  = $clog2(TICK_DIV);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCAN   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic [1:0]        state;
  logic [IDX_W-1:0]  idx;
  logic              l_data;
  logic [KEY_W-1:0]  l_key;
  logic [FACE_W-1:0] l_face;
  logic              m_found;
  logic [IDX_W-1:0]  m_idx;
  logic              f_found;
  logic [IDX_W-1:0]  f_idx;
  logic [PS_W-1:0]   presc;
  logic              tick_pending;

  logic              ent_valid [DEPTH];
  logic [KEY_W-1:0]  ent_key   [DEPTH];
  logic [FACES-1:0]  ent_faces [DEPTH];
  logic [LIFE_W-1:0] ent_life  [DEPTH];

  logic              accept_int;
  logic              accept_data;
  logic              aging;
  logic              wrap;
  logic [FACES-1:0]  face_oh;
  logic [OCC_W-1:0]  exp_cnt;

  assign data_ready  = (state == S_IDLE) && !tick_pending && !reset;
  assign int_ready   = data_ready && !data_valid;
  assign accept_data = data_valid && data_ready;
  assign accept_int  = int_valid && int_ready;
  assign aging       = (state == S_IDLE) && tick_pending;
  assign wrap        = (presc == PS_W'(TICK_DIV - 1));
  assign face_oh     = FACES'(1) << l_face;

  // entries that reach zero on the coming aging edge
  always_comb begin
    exp_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && ent_life[i] == LIFE_W'(1))
        exp_cnt = exp_cnt + OCC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      idx          <= '0;
      l_data       <= 1'b0;
      l_key        <= '0;
      l_face       <= '0;
      m_found      <= 1'b0;
      m_idx        <= '0;
      f_found      <= 1'b0;
      f_idx        <= '0;
      presc        <= '0;
      tick_pending <= 1'b0;
      fib_out      <= 1'b0;
      fib_key      <= '0;
      hit          <= 1'b0;
      hit_faces    <= '0;
      agg          <= 1'b0;
      dup          <= 1'b0;
      drop         <= 1'b0;
      expire       <= 1'b0;
      occupancy    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_valid[i] <= 1'b0;
        ent_key[i]   <= '0;
        ent_faces[i] <= '0;
        ent_life[i]  <= '0;
      end
    end else begin
      fib_out <= 1'b0;
      hit     <= 1'b0;
      agg     <= 1'b0;
      dup     <= 1'b0;
      drop    <= 1'b0;
      expire  <= 1'b0;
      presc   <= wrap ? '0 : presc + PS_W'(1);
      // a wrap during a pending tick merges into it
      if (wrap)
        tick_pending <= 1'b1;
      else if (aging)
        tick_pending <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (aging) begin
            for (int i = 0; i < DEPTH; i++) begin
              if (ent_valid[i]) begin
                ent_life[i] <= ent_life[i] - LIFE_W'(1);
                if (ent_life[i] == LIFE_W'(1))
                  ent_valid[i] <= 1'b0;
              end
            end
            expire    <= (exp_cnt != '0);
            occupancy <= occupancy - exp_cnt;
          end else if (accept_data || accept_int) begin
            l_data  <= accept_data;
            l_key   <= accept_data ? data_key : int_key;
            l_face  <= int_face;
            m_found <= 1'b0;
            m_idx   <= '0;
            f_found <= 1'b0;
            f_idx   <= '0;
            idx     <= '0;
            state   <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (!m_found && ent_valid[idx] && ent_key[idx] == l_key) begin
            m_found <= 1'b1;
            m_idx   <= idx;
          end
          if (!f_found && !ent_valid[idx]) begin
            f_found <= 1'b1;
            f_idx   <= idx;
          end
          if (idx == IDX_W'(DEPTH - 1))
            state <= S_COMMIT;
          else
            idx <= idx + IDX_W'(1);
        end
        S_COMMIT: begin
          state <= S_IDLE;
          unique case (1'b1)
            l_data && m_found: begin
              hit              <= 1'b1;
              hit_faces        <= ent_faces[m_idx];
              ent_valid[m_idx] <= 1'b0;
              occupancy        <= occupancy - OCC_W'(1);
            end
            !l_data && m_found: begin
              agg              <= 1'b1;
              dup              <= |(ent_faces[m_idx] & face_oh);
              ent_faces[m_idx] <= ent_faces[m_idx] | face_oh;
              ent_life[m_idx]  <= LIFE_W'(LIFE);
            end
            !l_data && !m_found && f_found: begin
              ent_valid[f_idx] <= 1'b1;
              ent_key[f_idx]   <= l_key;
              ent_faces[f_idx] <= face_oh;
              ent_life[f_idx]  <= LIFE_W'(LIFE);
              fib_out          <= 1'b1;
              fib_key          <= l_key;
              occupancy        <= occupancy + OCC_W'(1);
            end
            default: drop <= 1'b1;
          endcase
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pit_engine.sv
// tb_pit_engine: scenario tasks plus randomized traffic checked
// against an associative-array model of the pending interest table.
module tb_pit_engine;
  localparam int KEY_W    = 12;
  localparam int DEPTH    = 4;
  localparam int FACES    = 4;
  localparam int FACE_W   = 2;
  localparam int LIFE_W   = 8;
  localparam int LIFE     = 3;
  localparam int TICK_DIV = 16;
  localparam int OCC_W    = 3;

  logic clk, reset;
  logic int_valid, int_ready, data_valid, data_ready;
  logic [KEY_W-1:0] int_key, data_key, fib_key;
  logic [FACE_W-1:0] int_face;
  logic fib_out, hit, agg, dup, drop, expire;
  logic [FACES-1:0] hit_faces;
  logic [OCC_W-1:0] occupancy;

  pit_engine #(
    .KEY_W(KEY_W), .DEPTH(DEPTH), .FACES(FACES),
    .LIFE_W(LIFE_W), .LIFE(LIFE), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk(clk), .reset(reset),
    .int_valid(int_valid), .int_ready(int_ready),
    .int_key(int_key), .int_face(int_face),
    .data_valid(data_valid), .data_ready(data_ready),
    .data_key(data_key),
    .fib_out(fib_out), .fib_key(fib_key),
    .hit(hit), .hit_faces(hit_faces),
    .agg(agg), .dup(dup), .drop(drop),
    .expire(expire), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model: key -> face set / remaining lifetime
  logic [FACES-1:0] m_faces [int];
  int m_life [int];
  int m_presc, m_busy, m_ticks;
  bit m_pending, m_exp;
  logic [KEY_W-1:0] e_fib_key;
  logic [FACES-1:0] e_hit_faces;

  logic obs_exp, obs_rdy_scan, obs_early, acc_int_rdy;
  logic [4:0] obs, expv;

  task automatic model_reset();
    m_faces.delete();
    m_life.delete();
    m_presc = 0;
    m_busy = 0;
    m_pending = 0;
    m_exp = 0;
    e_fib_key = '0;
    e_hit_faces = '0;
  endtask

  // one clock edge; the model advances time, ticks and aging
  task automatic step();
    bit wrap, idle;
    int q[$];
    @(posedge clk);
    wrap = (m_presc == TICK_DIV - 1);
    idle = (m_busy == 0);
    m_exp = 0;
    if (idle && m_pending) begin
      m_ticks++;
      foreach (m_life[k]) begin
        m_life[k] = m_life[k] - 1;
        if (m_life[k] == 0) q.push_back(k);
      end
      foreach (q[i]) begin
        m_life.delete(q[i]);
        m_faces.delete(q[i]);
      end
      m_exp = (q.size() != 0);
    end
    if (wrap) m_pending = 1;
    else if (idle && m_pending) m_pending = 0;
    m_presc = wrap ? 0 : m_presc + 1;
    if (m_busy > 0) m_busy--;
    #1;
    obs_exp = expire;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    int_valid = 1'b0;
    data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic wait_ready();
    int n = 0;
    while ((m_busy != 0 || m_pending) && n < 50) begin
      step();
      n++;
    end
  endtask

  // issue one request, run it to completion, leave obs and expv
  task automatic do_req(input bit is_data, input bit both,
                        input int key, input int face);
    logic [FACES-1:0] f;
    int_key = KEY_W'(key);
    data_key = KEY_W'(key);
    int_face = FACE_W'(face);
    wait_ready();
    data_valid = is_data;
    int_valid = !is_data || both;
    #1;
    acc_int_rdy = int_ready;
    checks++;
    if ((is_data ? data_ready : int_ready) !== 1'b1) begin
      $display("FAIL accept_ready key=%h got=0 exp=1", key);
      errors++;
    end
    step();
    m_busy = DEPTH + 1;
    int_valid = 1'b0;
    data_valid = 1'b0;
    obs_rdy_scan = 1'b0;
    obs_early = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      step();
      if (i < DEPTH)
        obs_rdy_scan = obs_rdy_scan | data_ready | int_ready;
      if (i == DEPTH - 1)
        obs_early = fib_out | agg | hit | drop;
    end
    obs = {fib_out, agg, dup, hit, drop};
    expv = '0;
    if (is_data) begin
      if (m_faces.exists(key)) begin
        expv[1] = 1'b1;
        e_hit_faces = m_faces[key];
        m_faces.delete(key);
        m_life.delete(key);
      end else expv[0] = 1'b1;
    end else if (m_faces.exists(key)) begin
      f = m_faces[key];
      expv[3] = 1'b1;
      expv[2] = f[face];
      m_faces[key] = f | (FACES'(1) << face);
      m_life[key] = LIFE;
    end else if (m_faces.num() < DEPTH) begin
      expv[4] = 1'b1;
      e_fib_key = KEY_W'(key);
      m_faces[key] = FACES'(1) << face;
      m_life[key] = LIFE;
    end else expv[0] = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    int_valid = 1'b1;
    data_valid = 1'b1;
    #3;
    checks++;
    if ({data_ready, int_ready} !== 2'b00) begin
      $display("FAIL reset_ready got=%b exp=00", {data_ready, int_ready});
      errors++;
    end
    checks++;
    if ({fib_out, hit, agg, dup, drop, expire} !== 6'b0) begin
      $display("FAIL reset_pulses got=%b exp=0",
               {fib_out, hit, agg, dup, drop, expire});
      errors++;
    end
    checks++;
    if ({fib_key, hit_faces, occupancy} !== '0) begin
      $display("FAIL reset_regs fib_key=%h hit_faces=%b occ=%0d exp=0",
               fib_key, hit_faces, occupancy);
      errors++;
    end
    reset_dut();
  endtask

  task automatic test_insert();
    reset_dut();
    do_req(0, 0, 'h123, 2);
    checks++;
    if (obs !== expv) begin
      $display("FAIL insert_pulses got=%b exp=%b", obs, expv);
      errors++;
    end
    checks++;
    if (fib_key !== e_fib_key) begin
      $display("FAIL insert_fib_key got=%h exp=%h", fib_key, e_fib_key);
      errors++;
    end
    checks++;
    if (occupancy !== OCC_W'(m_faces.num())) begin
      $display("FAIL insert_occ got=%0d exp=%0d", occupancy, m_faces.num());
      errors++;
    end
    checks++;
    if (obs_rdy_scan !== 1'b0) begin
      $display("FAIL insert_ready_scan got=%b exp=0", obs_rdy_scan);
      errors++;
    end
    checks++;
    if (obs_early !== 1'b0) begin
      $display("FAIL insert_early_pulse got=%b exp=0", obs_early);
      errors++;
    end
  endtask

  task automatic test_aggregate();
    do_req(0, 0, 'h123, 0);
    checks++;
    if (obs !== expv) begin
      $display("FAIL agg_first got=%b exp=%b", obs, expv);
      errors++;
    end
    do_req(0, 0, 'h123, 0);
    checks++;
    if (obs !== expv) begin
      $display("FAIL agg_dup got=%b exp=%b", obs, expv);
      errors++;
    end
    do_req(1, 0, 'h123, 0);
    checks++;
    if (obs !== expv) begin
      $display("FAIL agg_hit got=%b exp=%b", obs, expv);
      errors++;
    end
    checks++;
    if (hit_faces !== e_hit_faces) begin
      $display("FAIL agg_hit_faces got=%b exp=%b", hit_faces, e_hit_faces);
      errors++;
    end
    checks++;
    if (occupancy !== OCC_W'(m_faces.num())) begin
      $display("FAIL agg_occ got=%0d exp=%0d", occupancy, m_faces.num());
      errors++;
    end
  endtask

  task automatic test_full();
    reset_dut();
    for (int k = 1; k <= 4; k++) begin
      do_req(0, 0, k, int'($urandom_range(3)));
      checks++;
      if (obs !== expv) begin
        $display("FAIL full_insert key=%0d got=%b exp=%b", k, obs, expv);
        errors++;
      end
    end
    do_req(0, 0, 'h005, 0);
    checks++;
    if (obs !== expv) begin
      $display("FAIL full_drop got=%b exp=%b", obs, expv);
      errors++;
    end
    checks++;
    if (occupancy !== OCC_W'(m_faces.num())) begin
      $display("FAIL full_occ got=%0d exp=%0d", occupancy, m_faces.num());
      errors++;
    end
    do_req(0, 0, 'h002, 3);
    checks++;
    if (obs !== expv) begin
      $display("FAIL full_agg got=%b exp=%b", obs, expv);
      errors++;
    end
  endtask

  task automatic test_miss();
    reset_dut();
    do_req(0, 0, 'h123, 1);
    do_req(1, 0, 'h0AA, 0);
    checks++;
    if (obs !== expv) begin
      $display("FAIL miss_pulses got=%b exp=%b", obs, expv);
      errors++;
    end
    checks++;
    if (occupancy !== OCC_W'(m_faces.num())) begin
      $display("FAIL miss_occ got=%0d exp=%0d", occupancy, m_faces.num());
      errors++;
    end
    checks++;
    if (hit_faces !== e_hit_faces) begin
      $display("FAIL miss_hit_faces got=%b exp=%b", hit_faces, e_hit_faces);
      errors++;
    end
  endtask

  task automatic test_aging();
    int t0, n;
    bit seen;
    reset_dut();
    do_req(0, 0, 'h055, 0);
    t0 = m_ticks;
    n = 0;
    seen = 0;
    while (m_ticks < t0 + 3 && n < 200) begin
      step();
      n++;
      seen = seen | obs_exp;
      checks++;
      if (obs_exp !== m_exp) begin
        $display("FAIL aging_expire got=%b exp=%b", obs_exp, m_exp);
        errors++;
      end
    end
    checks++;
    if (seen !== 1'b1) begin
      $display("FAIL aging_seen got=%b exp=1", seen);
      errors++;
    end
    checks++;
    if (occupancy !== OCC_W'(m_faces.num())) begin
      $display("FAIL aging_occ got=%0d exp=%0d", occupancy, m_faces.num());
      errors++;
    end
    do_req(1, 0, 'h055, 0);
    checks++;
    if (obs !== expv) begin
      $display("FAIL aging_data got=%b exp=%b", obs, expv);
      errors++;
    end
    reset_dut();
    do_req(0, 0, 'h055, 0);
    t0 = m_ticks;
    n = 0;
    while (m_ticks < t0 + 2 && n < 200) begin
      step();
      n++;
    end
    do_req(0, 0, 'h055, 1);
    checks++;
    if (obs !== expv) begin
      $display("FAIL refresh_agg got=%b exp=%b", obs, expv);
      errors++;
    end
    n = 0;
    while (m_ticks < t0 + 3 && n < 200) begin
      step();
      n++;
      checks++;
      if (obs_exp !== m_exp) begin
        $display("FAIL refresh_expire got=%b exp=%b", obs_exp, m_exp);
        errors++;
      end
    end
    checks++;
    if (occupancy !== OCC_W'(m_faces.num())) begin
      $display("FAIL refresh_occ got=%0d exp=%0d", occupancy, m_faces.num());
      errors++;
    end
  endtask

  task automatic test_priority();
    reset_dut();
    do_req(0, 0, 'h123, 1);
    do_req(1, 1, 'h123, 0);
    checks++;
    if (acc_int_rdy !== 1'b0) begin
      $display("FAIL prio_int_ready got=%b exp=0", acc_int_rdy);
      errors++;
    end
    checks++;
    if (obs !== expv) begin
      $display("FAIL prio_data got=%b exp=%b", obs, expv);
      errors++;
    end
    checks++;
    if (occupancy !== OCC_W'(m_faces.num())) begin
      $display("FAIL prio_occ got=%0d exp=%0d", occupancy, m_faces.num());
      errors++;
    end
  endtask

  task automatic test_reset_scan();
    reset_dut();
    do_req(0, 0, 'h123, 1);
    wait_ready();
    int_key = 'h0C3;
    int_face = '0;
    int_valid = 1'b1;
    step();
    int_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
    checks++;
    if ({fib_out, hit, agg, dup, drop, expire, data_ready, int_ready} !== 8'b0) begin
      $display("FAIL scan_reset_pulses got=%b exp=0",
               {fib_out, hit, agg, dup, drop, expire, data_ready, int_ready});
      errors++;
    end
    checks++;
    if ({fib_key, hit_faces, occupancy} !== '0) begin
      $display("FAIL scan_reset_regs fib_key=%h hit_faces=%b occ=%0d exp=0",
               fib_key, hit_faces, occupancy);
      errors++;
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    do_req(1, 0, 'h0C3, 0);
    checks++;
    if (obs !== expv) begin
      $display("FAIL scan_reset_data got=%b exp=%b", obs, expv);
      errors++;
    end
  endtask

  task automatic test_random();
    int gap;
    reset_dut();
    for (int t = 0; t < 40; t++) begin
      gap = int'($urandom_range(9));
      for (int g = 0; g < gap; g++) begin
        step();
        checks++;
        if (obs_exp !== m_exp) begin
          $display("FAIL rand_expire t=%0d got=%b exp=%b", t, obs_exp, m_exp);
          errors++;
        end
      end
      do_req($urandom_range(2) == 0, 0, 'h200 + int'($urandom_range(5)),
             int'($urandom_range(3)));
      checks++;
      if (obs !== expv) begin
        $display("FAIL rand_pulses t=%0d got=%b exp=%b", t, obs, expv);
        errors++;
      end
      checks++;
      if (occupancy !== OCC_W'(m_faces.num())) begin
        $display("FAIL rand_occ t=%0d got=%0d exp=%0d", t, occupancy,
                 m_faces.num());
        errors++;
      end
      checks++;
      if (fib_key !== e_fib_key || hit_faces !== e_hit_faces) begin
        $display("FAIL rand_regs t=%0d fib_key=%h/%h hit_faces=%b/%b", t,
                 fib_key, e_fib_key, hit_faces, e_hit_faces);
        errors++;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    int_valid = 1'b0;
    data_valid = 1'b0;
    int_key = '0;
    data_key = '0;
    int_face = '0;
    m_ticks = 0;
    model_reset();
    test_reset();
    test_insert();
    test_aggregate();
    test_full();
    test_miss();
    test_aging();
    test_priority();
    test_reset_scan();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
